// File: rtl/gng_poly_pkg.sv
// gng_poly_pkg: shared widths, pipeline constants and arithmetic helpers for
// the Gaussian noise generator polynomial evaluator.
//
// Contents:
//   X_W, C_W, P_W, Y_W, FRAC : operand, coefficient, product, result widths
//                              and the fractional scale of x
//   LATENCY                  : valid_in to valid_out delay in clocks
//   SAT_MAX / SAT_MIN        : 18-bit signed saturation bounds
//   sat_t / sat18()          : 20-bit to 18-bit saturation with overflow flag
//   scale_prod()             : product rescale by 2^-FRAC
//
// Optional build macro: GNG_POLY_ROUND_EN
//   When defined, scale_prod() rounds half-up before shifting.
//   When undefined, scale_prod() floors (plain arithmetic shift).
package gng_poly_pkg;

    localparam int X_W     = 15;
    localparam int C_W     = 18;
    localparam int P_W     = 34;
    localparam int Y_W     = 18;
    localparam int FRAC    = 15;
    localparam int LATENCY = 7;

    localparam logic signed [19:0] SAT_MAX = 20'sd131071;
    localparam logic signed [19:0] SAT_MIN = -20'sd131072;

    typedef struct packed {
        logic [Y_W-1:0] val;
        logic           ovf;
    } sat_t;

    // Clamp a 20-bit signed sum into the 18-bit signed range.
    function automatic sat_t sat18(input logic signed [19:0] v);
        sat_t r;
        if (v > SAT_MAX) begin
            r.val = SAT_MAX[Y_W-1:0];
            r.ovf = 1'b1;
        end else if (v < SAT_MIN) begin
            r.val = SAT_MIN[Y_W-1:0];
            r.ovf = 1'b1;
        end else begin
            r.val = v[Y_W-1:0];
            r.ovf = 1'b0;
        end
        return r;
    endfunction

    // Rescale a multiplier product by 2^-FRAC. The product magnitude stays
    // below 2^32, so adding the rounding constant cannot overflow 34 bits, and
    // the top 19 bits after the shift sign-extend cleanly into 20 bits.
    function automatic logic signed [19:0] scale_prod(input logic signed [P_W-1:0] p);
        logic signed [P_W-1:0] q;
`ifdef GNG_POLY_ROUND_EN
        q = p + 34'sd16384;
`else
        q = p;
`endif
        return {q[P_W-1], q[P_W-1:FRAC]};
    endfunction

endpackage

// File: rtl/gng_smul_16_18.sv
// gng_smul_16_18: 16x18 signed multiplier with a two-clock latency
// (registered operands, then registered product).
//
// Ports:
//   clk  : clock
//   rstn : synchronous active-low reset, clears operand and product registers
//   a    : 16-bit signed operand
//   b    : 18-bit signed operand
//   p    : 34-bit signed product, valid two clocks after a/b are presented
module gng_smul_16_18 (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] a,
    input  logic [17:0] b,
    output logic [33:0] p
);

    logic signed [15:0] a_r;
    logic signed [17:0] b_r;
    logic signed [33:0] a_x;
    logic signed [33:0] b_x;

    // Sign-extend both operands to the full product width before multiplying.
    assign a_x = 34'(a_r);
    assign b_x = 34'(b_r);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            a_r <= '0;
            b_r <= '0;
            p   <= '0;
        end else begin
            a_r <= a;
            b_r <= b;
            p   <= a_x * b_x;
        end
    end

endmodule

// File: rtl/gng_poly_eval.sv
// gng_poly_eval: streaming second-order polynomial evaluator
//   y = sat18(c0 + ((sat18(c1 + ((c2*x) >>> 15)) * x) >>> 15))
// Seven-clock fixed latency, one sample per clock, no backpressure.
//
// Stage map (edge that samples valid_in = E1):
//   E1 input registers, E2-E3 multiplier 1 (c2*x), E4 s1 register,
//   E5-E6 multiplier 2 (s1*x), E7 output register.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   valid_in   : input sample qualifier
//   x_in       : unsigned fraction, scale 2^-15
//   c0/c1/c2_in: signed 18-bit coefficients
//   clr_cnt    : synchronous clear of sat_cnt (wins over an increment)
//   valid_out  : output qualifier, valid_in delayed by 7 clocks
//   y_out      : signed 18-bit result, held between valid samples
//   sat_out    : either adder saturated for this sample, held like y_out
//   sat_cnt    : saturating count of valid samples with sat_out set
//
// Optional build macro: GNG_POLY_ROUND_EN (round half-up before each shift;
// default build floors). Latency is identical in both builds.
module gng_poly_eval
    import gng_poly_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [14:0]      x_in,
    input  logic [17:0]      c0_in,
    input  logic [17:0]      c1_in,
    input  logic [17:0]      c2_in,
    input  logic             clr_cnt,
    output logic             valid_out,
    output logic [17:0]      y_out,
    output logic             sat_out,
    output logic [CNT_W-1:0] sat_cnt
);

    // Valid tag: vpipe[k] holds the tag of the sample registered at edge E(k+1).
    logic [LATENCY-1:0] vpipe;

    // Stage 1 input registers.
    logic [X_W-1:0] x_s1;
    logic [C_W-1:0] c0_s1, c1_s1, c2_s1;

    // Alignment delays: x feeds multiplier 2 after E4, c1 feeds the E4 adder,
    // c0 feeds the E7 adder, and the stage-1 overflow flag rides to E7.
    logic [X_W-1:0] x_d2, x_d3, x_d4;
    logic [C_W-1:0] c1_d2, c1_d3;
    logic [C_W-1:0] c0_d2, c0_d3, c0_d4, c0_d5, c0_d6;
    logic           sat1_d5, sat1_d6;

    // Stage 4 register.
    logic [C_W-1:0] s1_r;
    logic           sat1_r;

    // Multiplier outputs.
    logic [P_W-1:0] p1, p2;

    // Combinational adders.
    logic signed [19:0] t1, t2;
    logic signed [19:0] sum1, sum2;
    sat_t               s1_sat, y_sat;
    logic               sat_any;
    logic               cnt_full;

    gng_smul_16_18 u_mul1 (
        .clk  (clk),
        .rstn (~rst),
        .a    ({1'b0, x_s1}),
        .b    (c2_s1),
        .p    (p1)
    );

    gng_smul_16_18 u_mul2 (
        .clk  (clk),
        .rstn (~rst),
        .a    ({1'b0, x_d4}),
        .b    (s1_r),
        .p    (p2)
    );

    always_comb begin
        t1      = scale_prod($signed(p1));
        sum1    = {{2{c1_d3[C_W-1]}}, c1_d3} + t1;
        s1_sat  = sat18(sum1);
        t2      = scale_prod($signed(p2));
        sum2    = {{2{c0_d6[C_W-1]}}, c0_d6} + t2;
        y_sat   = sat18(sum2);
        sat_any = sat1_d6 | y_sat.ovf;
        cnt_full = (sat_cnt == {CNT_W{1'b1}});
    end

    assign valid_out = vpipe[LATENCY-1];

    // Valid tag pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe <= '0;
        end else begin
            vpipe <= {vpipe[LATENCY-2:0], valid_in};
        end
    end

    // Data path registers. These move every clock regardless of the valid
    // tag; only tagged results reach the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_s1    <= '0;
            c0_s1   <= '0;
            c1_s1   <= '0;
            c2_s1   <= '0;
            x_d2    <= '0;
            x_d3    <= '0;
            x_d4    <= '0;
            c1_d2   <= '0;
            c1_d3   <= '0;
            c0_d2   <= '0;
            c0_d3   <= '0;
            c0_d4   <= '0;
            c0_d5   <= '0;
            c0_d6   <= '0;
            s1_r    <= '0;
            sat1_r  <= 1'b0;
            sat1_d5 <= 1'b0;
            sat1_d6 <= 1'b0;
        end else begin
            x_s1    <= x_in;
            c0_s1   <= c0_in;
            c1_s1   <= c1_in;
            c2_s1   <= c2_in;
            x_d2    <= x_s1;
            x_d3    <= x_d2;
            x_d4    <= x_d3;
            c1_d2   <= c1_s1;
            c1_d3   <= c1_d2;
            c0_d2   <= c0_s1;
            c0_d3   <= c0_d2;
            c0_d4   <= c0_d3;
            c0_d5   <= c0_d4;
            c0_d6   <= c0_d5;
            s1_r    <= s1_sat.val;
            sat1_r  <= s1_sat.ovf;
            sat1_d5 <= sat1_r;
            sat1_d6 <= sat1_d5;
        end
    end

    // Output register: vpipe[LATENCY-2] is the tag of the sample being
    // captured at E7, so results only change for valid samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_out   <= '0;
            sat_out <= 1'b0;
        end else if (vpipe[LATENCY-2]) begin
            y_out   <= y_sat.val;
            sat_out <= sat_any;
        end
    end

    // Saturation event counter, sticky at all-ones, clear has priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt <= '0;
        end else if (clr_cnt) begin
            sat_cnt <= '0;
        end else if (vpipe[LATENCY-2] && sat_any && !cnt_full) begin
            sat_cnt <= sat_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_gng_poly_eval.sv
// tb_gng_poly_eval: directed self-checking bench for gng_poly_eval.
// Expected results are hand-computed per vector; the GNG_POLY_ROUND_EN
// macro selects the rounding-dependent expectations.
module tb_gng_poly_eval;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [14:0] x_in;
    logic [17:0] c0_in, c1_in, c2_in;
    logic        clr_cnt;
    logic        valid_out;
    logic [17:0] y_out;
    logic        sat_out;
    logic [15:0] sat_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;
    logic [17:0] exp_q[$];

    gng_poly_eval #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .x_in      (x_in),
        .c0_in     (c0_in),
        .c1_in     (c1_in),
        .c2_in     (c2_in),
        .clr_cnt   (clr_cnt),
        .valid_out (valid_out),
        .y_out     (y_out),
        .sat_out   (sat_out),
        .sat_cnt   (sat_cnt)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        valid_in = 1'b0;
        x_in     = '0;
        c0_in    = '0;
        c1_in    = '0;
        c2_in    = '0;
    endtask

    // Send one isolated sample and check the pulse lands exactly 7 clocks
    // later. With clr set, clr_cnt is raised in the cycle whose edge captures
    // this sample's output, so it coincides with any increment.
    task automatic run_single(input string tag, input int x, input int c0,
                              input int c1, input int c2, input int exp_y,
                              input int exp_sat, input bit clr);
        logic [31:0] xv, c0v, c1v, c2v;
        xv = x; c0v = c0; c1v = c1; c2v = c2;
        valid_in = 1'b1;
        x_in     = xv[14:0];
        c0_in    = c0v[17:0];
        c1_in    = c1v[17:0];
        c2_in    = c2v[17:0];
        tick();
        drive_idle();
        for (int k = 2; k <= 7; k++) begin
            if (k == 7 && clr) clr_cnt = 1'b1;
            if (k < 7) check_eq({tag, "_early_valid"}, int'(valid_out), 0);
            tick();
        end
        clr_cnt = 1'b0;
        if (clr) exp_cnt = 0;
        else if (exp_sat != 0 && exp_cnt < 65535) exp_cnt++;
        check_eq({tag, "_valid"}, int'(valid_out), 1);
        check_eq({tag, "_y"}, int'($signed(y_out)), exp_y);
        check_eq({tag, "_sat"}, int'(sat_out), exp_sat);
        check_eq({tag, "_cnt"}, int'(sat_cnt), exp_cnt);
        tick();
        check_eq({tag, "_pulse_end"}, int'(valid_out), 0);
        check_eq({tag, "_y_hold"}, int'($signed(y_out)), exp_y);
    endtask

    initial begin
        logic       vin[14];
        logic [17:0] c0s[14];
        int          n;
        int          lo_y, fl_y;

        // Reset and idle.
        rst     = 1'b1;
        clr_cnt = 1'b0;
        drive_idle();
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("idle_valid", int'(valid_out), 0);
            check_eq("idle_y", int'(y_out), 0);
            check_eq("idle_sat", int'(sat_out), 0);
            check_eq("idle_cnt", int'(sat_cnt), 0);
        end

        // Constant term and latency.
        run_single("const", 12345, 1000, 0, 0, 1000, 0, 1'b0);

        // Full polynomial.
        run_single("poly_a", 16384, 0, 0, 32768, 8192, 0, 1'b0);
        run_single("poly_b", 16384, 500, -2000, 32768, 7692, 0, 1'b0);

        // Positive saturation in stage 1, then clear coinciding with the
        // next saturated sample, then negative saturation.
        run_single("sat_pos", 32767, 0, 131071, 131071, 131067, 1, 1'b0);
        run_single("sat_clr", 32767, 0, 131071, 131071, 131067, 1, 1'b1);
        run_single("sat_neg", 32767, 0, -131072, -131072, -131068, 1, 1'b0);

        // Output stage saturation only: c0 at max plus a positive t2.
        run_single("sat_out2", 32767, 131071, 1000, 0, 131071, 1, 1'b0);

        // Rounding-sensitive vectors.
`ifdef GNG_POLY_ROUND_EN
        lo_y = 1;
        fl_y = 0;
`else
        lo_y = 0;
        fl_y = -1;
`endif
        run_single("round_half", 16384, 0, 0, 1, lo_y, 0, 1'b0);
        run_single("neg_floor", 1, 0, 0, -1, fl_y, 0, 1'b0);

        // Streaming: 10 back-to-back samples then pattern 1,0,1,1.
        n = 14;
        for (int i = 0; i < 10; i++) begin
            vin[i] = 1'b1;
            c0s[i] = 18'(i);
        end
        vin[10] = 1'b1; vin[11] = 1'b0; vin[12] = 1'b1; vin[13] = 1'b1;
        c0s[10] = 18'd100; c0s[11] = 18'd101; c0s[12] = 18'd102; c0s[13] = 18'd103;
        for (int j = 0; j < n + 8; j++) begin
            if (j < n) begin
                valid_in = vin[j];
                x_in     = 15'd777;
                c0_in    = c0s[j];
                c1_in    = '0;
                c2_in    = '0;
                if (vin[j]) exp_q.push_back(c0s[j]);
            end else begin
                drive_idle();
            end
            tick();
            if (j >= 6 && j - 6 < n) check_eq("stream_valid", int'(valid_out), int'(vin[j-6]));
            else check_eq("stream_valid_edge", int'(valid_out), 0);
            if (valid_out) begin
                if (exp_q.size() > 0) check_eq("stream_y", int'(y_out), int'(exp_q.pop_front()));
                else check_eq("stream_extra", 1, 0);
            end
        end
        check_eq("stream_left", exp_q.size(), 0);

        // Reset mid-stream: burst of 6, reset from the 3rd cycle onward.
        for (int i = 0; i < 6; i++) begin
            valid_in = 1'b1;
            x_in     = 15'd100;
            c0_in    = 18'(50 + i);
            c1_in    = '0;
            c2_in    = '0;
            if (i >= 2) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        drive_idle();
        exp_cnt = 0;
        check_eq("rst_y", int'(y_out), 0);
        check_eq("rst_sat", int'(sat_out), 0);
        check_eq("rst_cnt", int'(sat_cnt), 0);
        for (int i = 0; i < 12; i++) begin
            check_eq("rst_no_valid", int'(valid_out), 0);
            tick();
        end
        run_single("post_rst", 5, -42, 0, 0, -42, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
